ex_div_unit: RTL and testbench



---
 rtl/ex_div_unit.sv | 130 +++++++++++++
 tb/tb_ex_div_unit.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
// It produces one quotient bit per clock and stalls the pipeline until the result is ready.
//
// state  | meaning
// IDLE   | waiting for start; operands are captured on the accepting edge
// BUSY   | one shift/trial-subtract per edge, WIDTH edges in total
// DONE   | result registers valid, done pulses for this one cycle
module ex_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_div,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             annul,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             stallreq
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   logic [1:0]       r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_prem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_dvs;
   logic             r_neg_q;
   logic             r_neg_r;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_dbz;

   logic [WIDTH-1:0] w_abs_dvd;
   logic [WIDTH-1:0] w_abs_dvs;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_trial;
   logic             w_bit;
   logic [WIDTH-1:0] w_prem_next;
   logic [WIDTH-1:0] w_quo_next;
   logic [WIDTH-1:0] w_q_fix;
   logic [WIDTH-1:0] w_r_fix;

   assign w_abs_dvd = (signed_div && dividend[WIDTH-1]) ? -dividend : dividend;
   assign w_abs_dvs = (signed_div && divisor[WIDTH-1])  ? -divisor  : divisor;

   // r_quo shifts the dividend out of its MSB while quotient bits shift in at the LSB
   assign w_shift     = {r_prem, r_quo[WIDTH-1]};
   assign w_trial     = w_shift - {1'b0, r_dvs};
   assign w_bit       = ~w_trial[WIDTH];
   assign w_prem_next = w_bit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
   assign w_quo_next  = {r_quo[WIDTH-2:0], w_bit};

   assign w_q_fix = r_neg_q ? -w_quo_next  : w_quo_next;
   assign w_r_fix = r_neg_r ? -w_prem_next : w_prem_next;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_prem      <= '0;
         r_quo       <= '0;
         r_dvs       <= '0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_dbz       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start && !annul) begin
                  if (divisor == '0) begin
                     r_quotient  <= '1;
                     r_remainder <= dividend;
                     r_dbz       <= 1'b1;
                     r_state     <= S_DONE;
                  end else begin
                     r_prem  <= '0;
                     r_quo   <= w_abs_dvd;
                     r_dvs   <= w_abs_dvs;
                     r_neg_q <= signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                     r_neg_r <= signed_div & dividend[WIDTH-1];
                     r_cnt   <= '0;
                     r_state <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               if (annul) begin
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
               end else begin
                  r_prem <= w_prem_next;
                  r_quo  <= w_quo_next;
                  if (r_cnt == LAST_ITER) begin
                     r_cnt       <= '0;
                     r_quotient  <= w_q_fix;
                     r_remainder <= w_r_fix;
                     r_dbz       <= 1'b0;
                     r_state     <= S_DONE;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy        = (r_state != S_IDLE);
   assign done        = (r_state == S_DONE) & ~annul;
   assign quotient    = r_quotient;
   assign remainder   = r_remainder;
   assign div_by_zero = r_dbz;
   // The stall drops in DONE so EX advances and consumes the result that same cycle
   assign stallreq    = rst & (((r_state == S_IDLE) & start & ~annul) | (r_state == S_BUSY));

endmodule

// File: tb/tb_ex_div_unit.sv
// Bench for ex_div_unit: an event-time reference model checked every cycle,
// plus directed divides with literal expected results and latencies.
module tb_ex_div_unit;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             signed_div;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             annul;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;
   logic             stallreq;

   int checks   = 0;
   int failures = 0;

   ex_div_unit #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .signed_div (signed_div),
      .dividend   (dividend),
      .divisor    (divisor),
      .annul      (annul),
      .busy       (busy),
      .done       (done),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero),
      .stallreq   (stallreq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Architectural DIV/DIVU result: C truncating division, remainder follows the dividend.
   function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r,
                                   output logic dz);
      int sa;
      int sb;
      sa = a;
      sb = b;
      dz = 1'b0;
      if (b == 32'd0) begin
         q  = 32'hFFFF_FFFF;
         r  = a;
         dz = 1'b1;
      end else if (!s) begin
         q = a / b;
         r = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 32'd0;
      end else begin
         q = sa / sb;
         r = sa % sb;
      end
   endfunction

   // Model: an accepted op returns to idle a fixed number of edges later; results appear one edge earlier.
   logic        m_active   = 1'b0;
   int          m_e        = 0;
   int          m_pub_edge = -10;
   int          m_end_edge = -10;
   logic [31:0] m_q        = '0;
   logic [31:0] m_r        = '0;
   logic        m_dz       = 1'b0;
   logic [31:0] p_q        = '0;
   logic [31:0] p_r        = '0;
   logic        p_dz       = 1'b0;

   initial begin
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            m_active = 1'b0;
            m_q      = '0;
            m_r      = '0;
            m_dz     = 1'b0;
         end else begin
            m_e++;
            if (m_active) begin
               if (annul) begin
                  m_active = 1'b0;
               end else begin
                  if (m_e == m_pub_edge) begin
                     m_q  = p_q;
                     m_r  = p_r;
                     m_dz = p_dz;
                  end
                  if (m_e == m_end_edge) m_active = 1'b0;
               end
            end else if (start && !annul) begin
               ref_div(signed_div, dividend, divisor, p_q, p_r, p_dz);
               m_active = 1'b1;
               if (divisor == '0) begin
                  m_pub_edge = m_e;
                  m_end_edge = m_e + 1;
                  m_q  = p_q;
                  m_r  = p_r;
                  m_dz = p_dz;
               end else begin
                  m_pub_edge = m_e + WIDTH;
                  m_end_edge = m_e + WIDTH + 1;
               end
            end
         end
      end
   end

   initial begin
      logic e_done;
      logic e_stall;
      forever begin
         @(negedge clk);
         e_done  = m_active && (m_e == m_pub_edge) && !annul;
         e_stall = rst && ((!m_active && start && !annul) || (m_active && (m_e != m_pub_edge)));
         chk("cyc_busy", {31'd0, busy}, {31'd0, m_active});
         chk("cyc_done", {31'd0, done}, {31'd0, e_done});
         chk("cyc_stallreq", {31'd0, stallreq}, {31'd0, e_stall});
         chk("cyc_quotient", quotient, m_q);
         chk("cyc_remainder", remainder, m_r);
         chk("cyc_dbz", {31'd0, div_by_zero}, {31'd0, m_dz});
      end
   end

   task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input int pulse_at, output int lat, output int stl);
      @(posedge clk);
      #1;
      start      = 1'b1;
      signed_div = s;
      dividend   = a;
      divisor    = b;
      stl        = 0;
      @(negedge clk);
      if (stallreq) stl++;
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = 32'hDEAD_BEEF;
      divisor  = 32'h0000_0000;
      lat      = 41;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (done) begin
            lat = n;
            break;
         end
         if (stallreq) stl++;
         #1;
         if (n == pulse_at) begin
            start      = 1'b1;
            signed_div = 1'b1;
            dividend   = 32'd1;
            divisor    = 32'd1;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      int lat;
      int stl;
      int ndone;
      rst        = 1'b1;
      start      = 1'b0;
      signed_div = 1'b0;
      dividend   = '0;
      divisor    = '0;
      annul      = 1'b0;
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_quotient", quotient, 32'd0);
      chk("rst_remainder", remainder, 32'd0);
      chk("rst_stallreq", {31'd0, stallreq}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;

      run_op(1'b0, 32'd100, 32'd7, 0, lat, stl);
      chk("divu_lat", lat, 32'd33);
      chk("divu_stall_cycles", stl, 32'd33);
      chk("divu_q", quotient, 32'd14);
      chk("divu_r", remainder, 32'd2);
      chk("divu_dbz", {31'd0, div_by_zero}, 32'd0);

      run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, lat, stl);
      chk("div_neg_q", quotient, 32'hFFFF_FFFD);
      chk("div_neg_r", remainder, 32'hFFFF_FFFF);

      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, stl);
      chk("div_ovf_q", quotient, 32'h8000_0000);
      chk("div_ovf_r", remainder, 32'd0);

      run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, stl);
      chk("divu_big_q", quotient, 32'd0);
      chk("divu_big_r", remainder, 32'h8000_0000);

      run_op(1'b1, 32'd50, 32'hFFFF_FFF9, 0, lat, stl);
      chk("div_pos_neg_q", quotient, 32'hFFFF_FFF9);
      chk("div_pos_neg_r", remainder, 32'd1);

      run_op(1'b0, 32'h0000_1234, 32'd0, 0, lat, stl);
      chk("dbz_lat", lat, 32'd1);
      chk("dbz_stall_cycles", stl, 32'd1);
      chk("dbz_q", quotient, 32'hFFFF_FFFF);
      chk("dbz_r", remainder, 32'h0000_1234);
      chk("dbz_flag", {31'd0, div_by_zero}, 32'd1);

      // annul mid-iteration
      @(posedge clk);
      #1;
      start = 1'b1; signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd3;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (9) @(posedge clk);
      #1 annul = 1'b1;
      @(posedge clk);
      #1 annul = 1'b0;
      @(negedge clk);
      chk("annul_busy", {31'd0, busy}, 32'd0);
      ndone = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("annul_no_done", ndone, 32'd0);
      chk("annul_q_held", quotient, 32'hFFFF_FFFF);
      chk("annul_r_held", remainder, 32'h0000_1234);
      run_op(1'b0, 32'd7, 32'd7, 0, lat, stl);
      chk("after_annul_lat", lat, 32'd33);
      chk("after_annul_q", quotient, 32'd1);
      chk("after_annul_r", remainder, 32'd0);
      chk("after_annul_dbz", {31'd0, div_by_zero}, 32'd0);

      // start together with annul in IDLE must be ignored
      @(posedge clk);
      #1;
      start = 1'b1; annul = 1'b1; dividend = 32'd5; divisor = 32'd1;
      @(negedge clk);
      chk("annul_start_stall", {31'd0, stallreq}, 32'd0);
      @(posedge clk);
      #1;
      start = 1'b0; annul = 1'b0;
      @(negedge clk);
      chk("annul_start_busy", {31'd0, busy}, 32'd0);

      // asynchronous reset mid-op
      @(posedge clk);
      #1;
      start = 1'b1; signed_div = 1'b0; dividend = 32'd5000; divisor = 32'd13;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (20) @(posedge clk);
      #2;
      start = 1'b1;
      rst   = 1'b0;
      #1;
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_done", {31'd0, done}, 32'd0);
      chk("arst_stallreq", {31'd0, stallreq}, 32'd0);
      chk("arst_q", quotient, 32'd0);
      chk("arst_r", remainder, 32'd0);
      chk("arst_dbz", {31'd0, div_by_zero}, 32'd0);
      @(posedge clk);
      #1;
      start = 1'b0;
      rst   = 1'b1;
      ndone = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("arst_no_done", ndone, 32'd0);

      // stray start during BUSY must not disturb the op in flight
      run_op(1'b0, 32'd77, 32'd5, 5, lat, stl);
      chk("busy_start_lat", lat, 32'd33);
      chk("busy_start_q", quotient, 32'd15);
      chk("busy_start_r", remainder, 32'd2);

      repeat (5) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
